// File: rtl/fft_pkg.sv
// Shared fixed-point definitions for the FFT datapath: word geometry, Q-format
// constants, the complex sample type and the saturate/truncate helpers.
package fft_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned FRACTION  = 8;

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1) << FRACTION;
  localparam logic [WORD_SIZE-1:0] MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0] MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

  typedef struct packed {
    logic signed [WORD_SIZE-1:0] re;
    logic signed [WORD_SIZE-1:0] im;
  } cplx_t;

  // True when v is representable as a w-bit two's complement value.
  function automatic logic fits_signed(input logic signed [63:0] v,
                                       input int unsigned         w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    return (v < lim) && (v >= -lim);
  endfunction

  // Clamp v to the w-bit two's complement range.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned         w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    if (v >= lim) begin
      return lim - 64'sd1;
    end
    if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

  // Drop f fractional bits with floor rounding (arithmetic shift).
  function automatic logic signed [63:0] trunc_frac(input logic signed [63:0] v,
                                                    input int unsigned         f);
    return v >>> f;
  endfunction

endpackage

// File: rtl/fx_cmul.sv
// Three-stage pipelined fixed-point complex multiply T = B * W.
//   S1: operand registers, S2: four partial products, S3: sums, truncation
//   and saturation.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_valid               operands present
//   i_br/i_bi, i_wr/i_wi  operand B and twiddle W
//   o_valid               valid aligned with o_tr/o_ti
//   o_tr, o_ti            truncated/saturated product
//   o_ovf_evt             product saturated (not qualified by valid)
module fx_cmul
  import fft_pkg::*;
#(
  parameter int unsigned WORD_SIZE = fft_pkg::WORD_SIZE,
  parameter int unsigned FRACTION  = fft_pkg::FRACTION
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_br,
  input  logic [WORD_SIZE-1:0] i_bi,
  input  logic [WORD_SIZE-1:0] i_wr,
  input  logic [WORD_SIZE-1:0] i_wi,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_tr,
  output logic [WORD_SIZE-1:0] o_ti,
  output logic                 o_ovf_evt
);

  localparam int unsigned PW = 2 * WORD_SIZE;
  localparam int unsigned SW = PW + 1;

  logic                        v1_q, v2_q, v3_q;
  logic signed [WORD_SIZE-1:0] br_q, bi_q, wr_q, wi_q;
  logic signed [PW-1:0]        p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [PW-1:0]        p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [SW-1:0]        pr_c, pi_c;
  logic signed [63:0]          pr_s_c, pi_s_c;
  logic signed [WORD_SIZE-1:0] tr_d, ti_d, tr_q, ti_q;
  logic                        ovf_d, ovf_q;

  // S1: operand capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_q <= 1'b0;
      br_q <= '0;
      bi_q <= '0;
      wr_q <= '0;
      wi_q <= '0;
    end else begin
      v1_q <= i_valid;
      br_q <= i_br;
      bi_q <= i_bi;
      wr_q <= i_wr;
      wi_q <= i_wi;
    end
  end

  // S2: full-width signed partial products.
  always_comb begin
    p_rr_d = PW'(br_q) * PW'(wr_q);
    p_ii_d = PW'(bi_q) * PW'(wi_q);
    p_ri_d = PW'(br_q) * PW'(wi_q);
    p_ir_d = PW'(bi_q) * PW'(wr_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v2_q   <= 1'b0;
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
    end else begin
      v2_q   <= v1_q;
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ri_q <= p_ri_d;
      p_ir_q <= p_ir_d;
    end
  end

  // S3: one extra bit for the sums, then floor-truncate and clamp.
  always_comb begin
    pr_c   = SW'(p_rr_q) - SW'(p_ii_q);
    pi_c   = SW'(p_ri_q) + SW'(p_ir_q);
    pr_s_c = trunc_frac(64'(pr_c), FRACTION);
    pi_s_c = trunc_frac(64'(pi_c), FRACTION);
    tr_d   = WORD_SIZE'(sat_signed(pr_s_c, WORD_SIZE));
    ti_d   = WORD_SIZE'(sat_signed(pi_s_c, WORD_SIZE));
    ovf_d  = !fits_signed(pr_s_c, WORD_SIZE) || !fits_signed(pi_s_c, WORD_SIZE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v3_q  <= 1'b0;
      tr_q  <= '0;
      ti_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      v3_q  <= v2_q;
      tr_q  <= tr_d;
      ti_q  <= ti_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_valid   = v3_q;
  assign o_tr      = tr_q;
  assign o_ti      = ti_q;
  assign o_ovf_evt = ovf_q;

endmodule

// File: rtl/fft_butterfly.sv
// Four-stage pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W.
// S1-S3 live in fx_cmul; A travels alongside in a matching delay line and
// S4 forms the sum/difference with optional 1/2 scaling or saturation.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_valid                 operand set present
//   i_ar/i_ai, i_br/i_bi    operands A and B
//   i_wr/i_wi               twiddle W
//   i_ovf_clr               synchronous clear of o_ovf (a new event wins)
//   o_valid                 result present on o_x*/o_y*
//   o_xr/o_xi, o_yr/o_yi    butterfly outputs
//   o_ovf                   sticky saturation flag
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int unsigned WORD_SIZE = fft_pkg::WORD_SIZE,
  parameter int unsigned FRACTION  = fft_pkg::FRACTION,
  parameter bit          SCALE     = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_ar,
  input  logic [WORD_SIZE-1:0] i_ai,
  input  logic [WORD_SIZE-1:0] i_br,
  input  logic [WORD_SIZE-1:0] i_bi,
  input  logic [WORD_SIZE-1:0] i_wr,
  input  logic [WORD_SIZE-1:0] i_wi,
  input  logic                 i_ovf_clr,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_xr,
  output logic [WORD_SIZE-1:0] o_xi,
  output logic [WORD_SIZE-1:0] o_yr,
  output logic [WORD_SIZE-1:0] o_yi,
  output logic                 o_ovf
);

  localparam int unsigned EW = WORD_SIZE + 1;

  logic                        v3_c, s3_evt_c;
  logic [WORD_SIZE-1:0]        tr_c, ti_c;
  logic signed [WORD_SIZE-1:0] ar1_q, ai1_q, ar2_q, ai2_q, ar3_q, ai3_q;
  logic signed [EW-1:0]        sxr_c, sxi_c, syr_c, syi_c;
  logic                        clip_c;
  logic [WORD_SIZE-1:0]        xr_d, xi_d, yr_d, yi_d;
  logic [WORD_SIZE-1:0]        xr_q, xi_q, yr_q, yi_q;
  logic                        valid_q;
  logic                        ovf_d, ovf_q;

  fx_cmul #(
    .WORD_SIZE (WORD_SIZE),
    .FRACTION  (FRACTION)
  ) u_cmul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_br      (i_br),
    .i_bi      (i_bi),
    .i_wr      (i_wr),
    .i_wi      (i_wi),
    .o_valid   (v3_c),
    .o_tr      (tr_c),
    .o_ti      (ti_c),
    .o_ovf_evt (s3_evt_c)
  );

  // A delay line, aligned with the product leaving S3.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ar1_q <= '0;
      ai1_q <= '0;
      ar2_q <= '0;
      ai2_q <= '0;
      ar3_q <= '0;
      ai3_q <= '0;
    end else begin
      ar1_q <= i_ar;
      ai1_q <= i_ai;
      ar2_q <= ar1_q;
      ai2_q <= ai1_q;
      ar3_q <= ar2_q;
      ai3_q <= ai2_q;
    end
  end

  // S4: add/sub on one guard bit, then halve or clamp.
  always_comb begin
    sxr_c  = EW'(ar3_q) + EW'($signed(tr_c));
    sxi_c  = EW'(ai3_q) + EW'($signed(ti_c));
    syr_c  = EW'(ar3_q) - EW'($signed(tr_c));
    syi_c  = EW'(ai3_q) - EW'($signed(ti_c));
    xr_d   = sxr_c[EW-1:1];
    xi_d   = sxi_c[EW-1:1];
    yr_d   = syr_c[EW-1:1];
    yi_d   = syi_c[EW-1:1];
    clip_c = 1'b0;
    if (!SCALE) begin
      xr_d   = WORD_SIZE'(sat_signed(64'(sxr_c), WORD_SIZE));
      xi_d   = WORD_SIZE'(sat_signed(64'(sxi_c), WORD_SIZE));
      yr_d   = WORD_SIZE'(sat_signed(64'(syr_c), WORD_SIZE));
      yi_d   = WORD_SIZE'(sat_signed(64'(syi_c), WORD_SIZE));
      clip_c = !fits_signed(64'(sxr_c), WORD_SIZE) || !fits_signed(64'(sxi_c), WORD_SIZE) ||
               !fits_signed(64'(syr_c), WORD_SIZE) || !fits_signed(64'(syi_c), WORD_SIZE);
    end
  end

  // Sticky overflow: the S3 event is already one stage late, so both event
  // sources qualify with the S3 valid and land with the result's o_valid.
  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (v3_c && (s3_evt_c || clip_c)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      xr_q    <= '0;
      xi_q    <= '0;
      yr_q    <= '0;
      yi_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= v3_c;
      xr_q    <= xr_d;
      xi_q    <= xi_d;
      yr_q    <= yr_d;
      yi_q    <= yi_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid = valid_q;
  assign o_xr    = xr_q;
  assign o_xi    = xi_q;
  assign o_yr    = yr_q;
  assign o_yi    = yi_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: a scaled and an unscaled instance share one
// stimulus stream; an integer-arithmetic butterfly model predicts every
// output cycle, including the sticky overflow flag.
module tb_fft_butterfly;
  import fft_pkg::*;

  typedef struct packed {
    logic  v;
    logic  clr;
    cplx_t a;
    cplx_t b;
    cplx_t w;
  } stim_t;

  typedef struct {
    logic [WORD_SIZE-1:0] xr, xi, yr, yi;
    bit                   evt;
  } res_t;

  logic                 clk, rst, valid, ovf_clr;
  logic [WORD_SIZE-1:0] ar, ai, br, bi, wr, wi;
  logic                 v_s1, ovf_s1, v_s0, ovf_s0;
  logic [WORD_SIZE-1:0] xr_s1, xi_s1, yr_s1, yi_s1;
  logic [WORD_SIZE-1:0] xr_s0, xi_s0, yr_s0, yi_s0;

  int       errors = 0;
  int       checks = 0;
  bit [1:0] exp_ovf = '0;
  stim_t    hist [4];

  fft_butterfly #(.WORD_SIZE(WORD_SIZE), .FRACTION(FRACTION), .SCALE(1'b1)) dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid),
    .i_ar(ar), .i_ai(ai), .i_br(br), .i_bi(bi), .i_wr(wr), .i_wi(wi),
    .i_ovf_clr(ovf_clr), .o_valid(v_s1),
    .o_xr(xr_s1), .o_xi(xi_s1), .o_yr(yr_s1), .o_yi(yi_s1), .o_ovf(ovf_s1)
  );

  fft_butterfly #(.WORD_SIZE(WORD_SIZE), .FRACTION(FRACTION), .SCALE(1'b0)) dut_s0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid),
    .i_ar(ar), .i_ai(ai), .i_br(br), .i_bi(bi), .i_wr(wr), .i_wi(wi),
    .i_ovf_clr(ovf_clr), .o_valid(v_s0),
    .o_xr(xr_s0), .o_xi(xi_s0), .o_yr(yr_s0), .o_yi(yi_s0), .o_ovf(ovf_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WORD_SIZE-1:0] act,
                     input logic [WORD_SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, inout bit evt);
    longint hi, lo;
    hi = (longint'(1) << (WORD_SIZE - 1)) - 1;
    lo = -(longint'(1) << (WORD_SIZE - 1));
    if (v > hi) begin evt = 1'b1; return hi; end
    if (v < lo) begin evt = 1'b1; return lo; end
    return v;
  endfunction

  function automatic res_t butterfly(input stim_t s, input bit scale);
    res_t   r;
    bit     evt;
    longint pr, pi, tr, ti, sx_r, sx_i, sy_r, sy_i;
    evt  = 1'b0;
    pr   = longint'($signed(s.b.re)) * longint'($signed(s.w.re))
         - longint'($signed(s.b.im)) * longint'($signed(s.w.im));
    pi   = longint'($signed(s.b.re)) * longint'($signed(s.w.im))
         + longint'($signed(s.b.im)) * longint'($signed(s.w.re));
    tr   = clamp(floor_div(pr, longint'(1) << FRACTION), evt);
    ti   = clamp(floor_div(pi, longint'(1) << FRACTION), evt);
    sx_r = longint'($signed(s.a.re)) + tr;
    sx_i = longint'($signed(s.a.im)) + ti;
    sy_r = longint'($signed(s.a.re)) - tr;
    sy_i = longint'($signed(s.a.im)) - ti;
    if (scale) begin
      sx_r = floor_div(sx_r, 2);
      sx_i = floor_div(sx_i, 2);
      sy_r = floor_div(sy_r, 2);
      sy_i = floor_div(sy_i, 2);
    end else begin
      sx_r = clamp(sx_r, evt);
      sx_i = clamp(sx_i, evt);
      sy_r = clamp(sy_r, evt);
      sy_i = clamp(sy_i, evt);
    end
    r.xr  = WORD_SIZE'(sx_r);
    r.xi  = WORD_SIZE'(sx_i);
    r.yr  = WORD_SIZE'(sy_r);
    r.yi  = WORD_SIZE'(sy_i);
    r.evt = evt;
    return r;
  endfunction

  function automatic stim_t mk(input logic v, input logic [WORD_SIZE-1:0] a_r, a_i,
                               b_r, b_i, w_r, w_i, input logic clr);
    stim_t s;
    s.v = v;     s.clr = clr;
    s.a.re = a_r; s.a.im = a_i;
    s.b.re = b_r; s.b.im = b_i;
    s.w.re = w_r; s.w.im = w_i;
    return s;
  endfunction

  function automatic logic [WORD_SIZE-1:0] rnd_word(input bit wide, input int unsigned span);
    if (wide) return WORD_SIZE'($urandom);
    return WORD_SIZE'($urandom_range(0, 2 * span - 1)) - WORD_SIZE'(span);
  endfunction

  function automatic stim_t rnd_stim(input logic v, input logic clr);
    bit wide;
    wide = ($urandom_range(0, 3) == 0);
    return mk(v, rnd_word(wide, 16'h4000), rnd_word(wide, 16'h4000),
              rnd_word(wide, 16'h2000), rnd_word(wide, 16'h2000),
              rnd_word(wide, 16'h0100), rnd_word(wide, 16'h0100), clr);
  endfunction

  // Hand-derived results that pin the model.
  task automatic pin_model();
    res_t r;
    r = butterfly(mk(1, ONE, 0, ONE, 0, ONE, 0, 0), 1'b1);
    chk("pin_identity_xr", r.xr, 16'h0100);
    chk("pin_identity_xi", r.xi, 16'h0000);
    chk("pin_identity_yr", r.yr, 16'h0000);
    chk("pin_identity_evt", 16'(r.evt), 16'h0000);
    r = butterfly(mk(1, 0, 0, ONE, 0, 0, 16'hFF00, 0), 1'b1);
    chk("pin_negj_xi", r.xi, 16'hFF80);
    chk("pin_negj_yi", r.yi, 16'h0080);
    chk("pin_negj_xr", r.xr, 16'h0000);
    r = butterfly(mk(1, 0, 0, 16'h0001, 0, 16'hFFFF, 0, 0), 1'b0);
    chk("pin_trunc_xr", r.xr, 16'hFFFF);
    chk("pin_trunc_yr", r.yr, 16'h0001);
    r = butterfly(mk(1, 16'h7F00, 0, ONE, 0, ONE, 0, 0), 1'b0);
    chk("pin_sat_xr", r.xr, MAX);
    chk("pin_sat_yr", r.yr, 16'h7E00);
    chk("pin_sat_evt", 16'(r.evt), 16'h0001);
    r = butterfly(mk(1, 16'h8000, 0, ONE, 0, ONE, 0, 0), 1'b0);
    chk("pin_sat_neg_yr", r.yr, MIN);
  endtask

  // ---------------- per-cycle compare --------------------------------------
  task automatic chk_zero(input string t, input logic ov, input logic [WORD_SIZE-1:0] oxr,
                          oxi, oyr, oyi, input logic oovf);
    chk({t, "_rst_valid"}, 16'(ov), 16'h0000);
    chk({t, "_rst_xr"}, oxr, 16'h0000);
    chk({t, "_rst_xi"}, oxi, 16'h0000);
    chk({t, "_rst_yr"}, oyr, 16'h0000);
    chk({t, "_rst_yi"}, oyi, 16'h0000);
    chk({t, "_rst_ovf"}, 16'(oovf), 16'h0000);
  endtask

  // hist[3] holds the operand set whose result is due now; hist[0] holds the
  // i_ovf_clr value sampled on this same edge.
  task automatic compare_one(input bit scale, input logic ov, input logic [WORD_SIZE-1:0] oxr,
                             oxi, oyr, oyi, input logic oovf);
    res_t  r;
    string t;
    t = scale ? "s1" : "s0";
    r = butterfly(hist[3], scale);
    chk({t, "_valid"}, 16'(ov), 16'(hist[3].v));
    if (hist[3].v) begin
      chk({t, "_xr"}, oxr, r.xr);
      chk({t, "_xi"}, oxi, r.xi);
      chk({t, "_yr"}, oyr, r.yr);
      chk({t, "_yi"}, oyi, r.yi);
    end
    exp_ovf[scale] = (hist[3].v && r.evt) || (exp_ovf[scale] && !hist[0].clr);
    chk({t, "_ovf"}, 16'(oovf), 16'(exp_ovf[scale]));
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk_zero("s1", v_s1, xr_s1, xi_s1, yr_s1, yi_s1, ovf_s1);
      chk_zero("s0", v_s0, xr_s0, xi_s0, yr_s0, yi_s0, ovf_s0);
      exp_ovf = '0;
    end else begin
      compare_one(1'b1, v_s1, xr_s1, xi_s1, yr_s1, yi_s1, ovf_s1);
      compare_one(1'b0, v_s0, xr_s0, xi_s0, yr_s0, yi_s0, ovf_s0);
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic drive(input stim_t s);
    @(negedge clk);
    valid   = s.v;
    ovf_clr = s.clr;
    ar = s.a.re; ai = s.a.im;
    br = s.b.re; bi = s.b.im;
    wr = s.w.re; wi = s.w.im;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk_zero("s1_async", v_s1, xr_s1, xi_s1, yr_s1, yi_s1, ovf_s1);
    chk_zero("s0_async", v_s0, xr_s0, xi_s0, yr_s0, yi_s0, ovf_s0);
    valid = 1'b0;
    ovf_clr = 1'b0;
    foreach (hist[i]) hist[i] = '0;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    foreach (hist[i]) hist[i] = '0;
    rst = 1'b1; valid = 1'b0; ovf_clr = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0; wr = '0; wi = '0;
    pin_model();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Directed vectors.
    drive(mk(1, ONE, 0, ONE, 0, ONE, 0, 0));
    drive(mk(1, 0, 0, ONE, 0, 0, 16'hFF00, 0));
    drive(mk(1, 0, 0, 16'h0001, 0, 16'hFFFF, 0, 0));
    idle(3);
    drive(mk(1, 16'h7F00, 0, ONE, 0, ONE, 0, 0));
    idle(6);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1));
    idle(2);
    // Clear arriving on the same edge as a new saturation: set must win.
    drive(mk(1, 16'h7F00, 0, ONE, 0, ONE, 0, 0));
    idle(2);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1));
    idle(4);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1));
    idle(2);

    // Streaming: 16 back-to-back, then gap pattern 1,0,1,1,0.
    for (int i = 0; i < 16; i++) drive(rnd_stim(1'b1, 1'b0));
    drive(rnd_stim(1'b1, 1'b0));
    drive(rnd_stim(1'b0, 1'b0));
    drive(rnd_stim(1'b1, 1'b0));
    drive(rnd_stim(1'b1, 1'b0));
    drive(rnd_stim(1'b0, 1'b0));
    idle(5);

    // Reset with three operations in flight.
    drive(rnd_stim(1'b1, 1'b0));
    drive(rnd_stim(1'b1, 1'b0));
    drive(rnd_stim(1'b1, 1'b0));
    idle(1);
    async_reset();
    idle(3);
    drive(mk(1, ONE, 0, ONE, 0, ONE, 0, 0));
    idle(6);

    // Random traffic with random valid gaps and clears.
    for (int i = 0; i < 200; i++) begin
      drive(rnd_stim(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 7) == 0)));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_butterfly.md
# fft_butterfly

Pipelined radix-2 decimation-in-time butterfly for the 16-point FFT datapath, in signed Q(WORD_SIZE-FRACTION).FRACTION fixed point. It sits directly downstream of the twiddle fetch and the operand buffer, and directly upstream of the result buffer. It multiplies B by twiddle W, then forms X = A + B·W and Y = A − B·W. The pipeline accepts one butterfly per clock and has no backpressure.

## Interface
- WORD_SIZE, 16: width of each real/imag component, two's complement
- FRACTION, 8: number of fractional bits
- SCALE, 1: 1 = outputs arithmetic-shifted right by 1 (per-stage 1/2 scaling); 0 = unscaled with saturation
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  operand set present this cycle
- i_ar, i_ai  in  WORD_SIZE each  operand A, real/imag
- i_br, i_bi  in  WORD_SIZE each  operand B, real/imag
- i_wr, i_wi  in  WORD_SIZE each  twiddle W, real/imag
- i_ovf_clr  in  1  synchronous clear of o_ovf
- o_valid  out  1  o_x*/o_y* hold a result this cycle
- o_xr, o_xi  out  WORD_SIZE each  X = A + B·W
- o_yr, o_yi  out  WORD_SIZE each  Y = A − B·W
- o_ovf  out  1  sticky saturation flag

## Operation
- Stage 1 (S1): register all six operands and i_valid.
- Stage 2 (S2): four signed 2·WORD_SIZE products: br·wr, bi·wi, br·wi, bi·wr. A is carried alongside.
- Stage 3 (S3):
  - Full-width sums: Pr = br·wr − bi·wi and Pi = br·wi + bi·wr, computed on 2·WORD_SIZE+1 bits.
  - Truncate: Tr/Ti = bits [WORD_SIZE−1+FRACTION : FRACTION]. This is floor rounding (arithmetic shift); for example, a product of −1 LSB² yields 0xFFFF.
  - If the sum does not fit in WORD_SIZE after the shift, saturate to 0x7FFF/0x8000 and raise the overflow event.
- Stage 4 (S4): sums and differences computed on WORD_SIZE+1 bits: X = A+T, Y = A−T.
  - SCALE=1: output bits [WORD_SIZE:1]. This cannot overflow.
  - SCALE=0: saturate to WORD_SIZE and raise the overflow event on any clip.
- Valid pipeline: a 4-deep shift register of i_valid drives o_valid.
- Data registers load on every clock regardless of valid. Outputs are don't-care when o_valid=0, but are deterministic (zero after reset).
- o_ovf:
  - Set when any overflow event occurs on a stage whose valid bit is 1.
  - Cleared by i_ovf_clr. If clear and set happen in the same cycle, set wins.
  - Events on invalid stages are ignored.
- The sign of every product is handled natively as signed multiply. There is no sign-magnitude conversion, so operand sign and data always travel in the same pipeline stage.

## Timing
- Latency: 4 cycles. i_valid at edge n produces o_valid at edge n+4 with the matching result.
- Throughput: 1 butterfly/cycle. Back-to-back valids produce back-to-back outputs. Gaps are preserved exactly.
- Reset (asynchronous, any time): all pipeline registers, o_valid, o_x*, o_y* and o_ovf go to 0 immediately. In-flight operations are discarded; no stale o_valid appears after release.
- The first valid input after reset deassertion is treated normally. The first o_valid appears 4 edges later.
- o_ovf rises on the same edge as the o_valid of the offending result (S3 events are delayed one cycle to align).

## Structure
- Shared package fft_pkg:
  - WORD_SIZE and FRACTION defaults
  - Q-format constants: ONE = 1<<FRACTION, MAX = 0x7FFF, MIN = 0x8000
  - saturate/truncate helper functions
  - complex sample typedef {re, im}
- Sub-module fx_cmul: S1–S3 complex multiply (registered operands, products, truncated/saturated T, overflow event, valid). fft_butterfly adds the A delay line and S4 add/sub/scale.

## Test plan
- Identity (SCALE=1): A=(0x0100,0), B=(0x0100,0), W=(0x0100,0) → 4 cycles later X=(0x0100,0), Y=(0,0), o_ovf=0.
- Twiddle −j (SCALE=1): A=(0,0), B=(0x0100,0), W=(0,0xFF00) → X=(0,0xFF80), Y=(0,0x0080).
- Truncation: A=0, B=(0x0001,0), W=(0xFFFF,0), SCALE=0 → X=(0xFFFF,0), Y=(0x0001,0).
- Saturation (SCALE=0): A=(0x7F00,0), B=(0x0100,0), W=(0x0100,0) → X=(0x7FFF,0), Y=(0x7E00,0), o_ovf=1 on that output edge; stays 1 until i_ovf_clr.
- Streaming: 16 back-to-back random valids, then a gap pattern 1,0,1,1,0 → outputs match the golden model in order, with o_valid reproducing the pattern delayed by 4.
- Reset mid-stream: assert i_rst asynchronously with 3 operations in flight → outputs 0 at once, no o_valid after release until 4 cycles after the next i_valid.
